// File: rtl/mul_share_sequencer.sv
// Two-port round-robin front end sharing one radix-2 shift-add multiplier.
// A product takes W iterations; signed inputs are multiplied as magnitudes and the result is negated at the end.
module mul_share_sequencer #(
  parameter int W  = 16,
  parameter int CW = 5
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             iReq0,
  input  logic [W-1:0]     iA0,
  input  logic [W-1:0]     iB0,
  input  logic             iSigned0,
  input  logic             iReq1,
  input  logic [W-1:0]     iA1,
  input  logic [W-1:0]     iB1,
  input  logic             iSigned1,
  output logic             oGrant0,
  output logic             oGrant1,
  output logic             oDone0,
  output logic             oDone1,
  output logic [2*W-1:0]   oResult,
  output logic             oBusy
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          r_state;
  logic            r_ptr;
  logic            r_owner;
  logic            r_neg;
  logic [W-1:0]    r_mcand;
  logic [W-1:0]    r_mul;
  logic [W-1:0]    r_acc;
  logic [CW-1:0]   r_cnt;

  logic            w_any;
  logic            w_win;
  logic [W-1:0]    w_a_sel;
  logic [W-1:0]    w_b_sel;
  logic            w_s_sel;
  logic [W-1:0]    w_abs_a;
  logic [W-1:0]    w_abs_b;
  logic [W:0]      w_sum;
  logic [2*W-1:0]  w_mag;
  logic [2*W-1:0]  w_prod;
  logic            w_last;

  // Pointer breaks ties; a lone request always wins.
  assign w_any   = iReq0 | iReq1;
  assign w_win   = (iReq0 & iReq1) ? r_ptr : iReq1;
  assign w_a_sel = w_win ? iA1 : iA0;
  assign w_b_sel = w_win ? iB1 : iB0;
  assign w_s_sel = w_win ? iSigned1 : iSigned0;
  assign w_abs_a = (w_s_sel & w_a_sel[W-1]) ? -w_a_sel : w_a_sel;
  assign w_abs_b = (w_s_sel & w_b_sel[W-1]) ? -w_b_sel : w_b_sel;

  // The carry out of the add becomes the new MSB after the right shift.
  assign w_sum  = {1'b0, r_acc} + {1'b0, (r_mul[0] ? r_mcand : {W{1'b0}})};
  assign w_mag  = {w_sum, r_mul[W-1:1]};
  assign w_prod = r_neg ? -w_mag : w_mag;
  assign w_last = (r_cnt == CW'(W - 1));

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_ptr   <= 1'b0;
      r_owner <= 1'b0;
      r_neg   <= 1'b0;
      r_mcand <= '0;
      r_mul   <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      oGrant0 <= 1'b0;
      oGrant1 <= 1'b0;
      oDone0  <= 1'b0;
      oDone1  <= 1'b0;
      oResult <= '0;
      oBusy   <= 1'b0;
    end else begin
      oGrant0 <= 1'b0;
      oGrant1 <= 1'b0;
      oDone0  <= 1'b0;
      oDone1  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_mcand <= w_abs_a;
            r_mul   <= w_abs_b;
            r_neg   <= w_s_sel & (w_a_sel[W-1] ^ w_b_sel[W-1]);
            r_acc   <= '0;
            r_cnt   <= '0;
            r_owner <= w_win;
            r_ptr   <= ~w_win;
            oGrant0 <= ~w_win;
            oGrant1 <= w_win;
            oBusy   <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_acc <= w_mag[2*W-1:W];
          r_mul <= w_mag[W-1:0];
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            oResult <= w_prod;
            oDone0  <= ~r_owner;
            oDone1  <= r_owner;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          oBusy   <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          oBusy   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_share_sequencer.sv
// Directed bench for mul_share_sequencer: products, signed magnitudes, arbitration order and mid-run reset.
module tb_mul_share_sequencer;

  logic        Clock;
  logic        Reset;
  logic        iReq0, iReq1, iSigned0, iSigned1;
  logic [15:0] iA0, iB0, iA1, iB1;
  logic        oGrant0, oGrant1, oDone0, oDone1, oBusy;
  logic [31:0] oResult;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  mul_share_sequencer #(.W(16), .CW(5)) dut (
    .Clock(Clock), .Reset(Reset),
    .iReq0(iReq0), .iA0(iA0), .iB0(iB0), .iSigned0(iSigned0),
    .iReq1(iReq1), .iA1(iA1), .iB1(iB1), .iSigned1(iSigned1),
    .oGrant0(oGrant0), .oGrant1(oGrant1), .oDone0(oDone0), .oDone1(oDone1),
    .oResult(oResult), .oBusy(oBusy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One request, scrambled operands after grant, done expected 16 cycles later.
  task automatic do_op(input int who, input logic [15:0] a, input logic [15:0] b,
                       input logic s, input logic [31:0] exp, input string tag);
    int n;
    logic got;
    logic [31:0] prev;
    if (who == 0) begin iA0 = a; iB0 = b; iSigned0 = s; iReq0 = 1'b1; end
    else          begin iA1 = a; iB1 = b; iSigned1 = s; iReq1 = 1'b1; end
    prev = oResult;
    n = 0; got = 1'b0;
    while (!got && n < 40) begin tick(); n++; got = oGrant0 | oGrant1; end
    check({tag, "_grant"}, {62'd0, oGrant1, oGrant0}, (who == 0) ? 64'd1 : 64'd2);
    check({tag, "_busyG"}, {63'd0, oBusy}, 64'd1);
    iReq0 = 1'b0; iReq1 = 1'b0;
    iA0 = ~a ^ 16'h5a5a; iB0 = b + 16'h1357; iSigned0 = ~s;
    iA1 = ~a ^ 16'ha5a5; iB1 = b + 16'h2468; iSigned1 = ~s;
    n = 0; got = 1'b0;
    while (!got && n < 40) begin
      tick(); n++;
      got = oDone0 | oDone1;
      if (!got) begin
        check({tag, "_hold"}, {32'd0, oResult}, {32'd0, prev});
        check({tag, "_busyR"}, {63'd0, oBusy}, 64'd1);
      end
    end
    check({tag, "_lat"}, 64'(n), 64'd16);
    check({tag, "_done"}, {62'd0, oDone1, oDone0}, (who == 0) ? 64'd1 : 64'd2);
    check({tag, "_res"}, {32'd0, oResult}, {32'd0, exp});
    check({tag, "_busyD"}, {63'd0, oBusy}, 64'd1);
    tick();
    check({tag, "_idle"}, {62'd0, oBusy, oDone0 | oDone1}, 64'd0);
    $display("op %s: who=%0d a=0x%04h b=0x%04h s=%0d result=0x%08h", tag, who, a, b, s, oResult);
  endtask

  initial begin
    int n, last_g, who;
    logic got;
    Reset = 1'b1;
    iReq0 = 0; iReq1 = 0; iSigned0 = 0; iSigned1 = 0;
    iA0 = 0; iB0 = 0; iA1 = 0; iB1 = 0;
    tick(); tick();
    check("rst_out", {58'd0, oGrant0, oGrant1, oDone0, oDone1, oBusy, 1'b0}, 64'd0);
    check("rst_res", {32'd0, oResult}, 64'd0);
    Reset = 1'b0;
    tick();

    do_op(0, 16'd3,    16'd5,    1'b0, 32'h0000000F, "u3x5");
    do_op(1, 16'hFFFD, 16'd5,    1'b1, 32'hFFFFFFF1, "sm3x5");
    do_op(1, 16'h8000, 16'h8000, 1'b1, 32'h40000000, "s8000sq");
    do_op(0, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, "uFFFFsq");
    do_op(0, 16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001, "sFFFFsq");
    do_op(0, 16'd7,    16'd9,    1'b0, 32'h0000003F, "u7x9chg");

    // Both requests held from reset: expect 0,1,0,1 spaced 18 cycles.
    Reset = 1'b1;
    iA0 = 16'd2; iB0 = 16'd3; iSigned0 = 1'b0;
    iA1 = 16'd4; iB1 = 16'd5; iSigned1 = 1'b0;
    iReq0 = 1'b1; iReq1 = 1'b1;
    tick();
    Reset = 1'b0;
    last_g = 0;
    for (int k = 0; k < 4; k++) begin
      n = 0; got = 1'b0;
      while (!got && n < 40) begin tick(); n++; got = oGrant0 | oGrant1; end
      who = oGrant1 ? 1 : 0;
      check("rr_grant", {62'd0, oGrant1, oGrant0}, (k % 2 == 0) ? 64'd1 : 64'd2);
      if (k > 0) check("rr_gap", 64'(cyc - last_g), 64'd18);
      last_g = cyc;
      n = 0; got = 1'b0;
      while (!got && n < 40) begin tick(); n++; got = oDone0 | oDone1; end
      if (k == 3) begin iReq0 = 1'b0; iReq1 = 1'b0; end
      check("rr_done", {62'd0, oDone1, oDone0}, (k % 2 == 0) ? 64'd1 : 64'd2);
      check("rr_res", {32'd0, oResult}, (k % 2 == 0) ? 64'd6 : 64'd20);
      $display("rr %0d: grant=%0d result=0x%08h cyc=%0d", k, who, oResult, cyc);
    end
    tick(); tick();

    // Reset 8 cycles into a run leaves the pointer on requester 1 unless reset restores it.
    iA0 = 16'h1234; iB0 = 16'h0010; iSigned0 = 1'b0; iReq0 = 1'b1;
    n = 0; got = 1'b0;
    while (!got && n < 40) begin tick(); n++; got = oGrant0; end
    check("mr_grant", {63'd0, oGrant0}, 64'd1);
    iReq0 = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    #2 Reset = 1'b1;
    #1;
    check("mr_clear", {59'd0, oGrant0, oGrant1, oDone0, oDone1, oBusy}, 64'd0);
    check("mr_res", {32'd0, oResult}, 64'd0);
    $display("midreset: busy=%0d result=0x%08h", oBusy, oResult);
    tick(); tick();
    Reset = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin tick(); got = got | oDone0 | oDone1 | oBusy; end
    check("mr_nodone", {63'd0, got}, 64'd0);
    iA0 = 16'd6; iB0 = 16'd7; iA1 = 16'd9; iB1 = 16'd9;
    iReq0 = 1'b1; iReq1 = 1'b1;
    n = 0; got = 1'b0;
    while (!got && n < 40) begin tick(); n++; got = oGrant0 | oGrant1; end
    check("mr_ptr", {62'd0, oGrant1, oGrant0}, 64'd1);
    iReq0 = 1'b0; iReq1 = 1'b0;
    n = 0; got = 1'b0;
    while (!got && n < 40) begin tick(); n++; got = oDone0 | oDone1; end
    check("mr_res2", {30'd0, oDone1, oDone0, oResult}, {30'd0, 2'b01, 32'd42});
    $display("after reset: result=0x%08h", oResult);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
